ssd1306_spi_capture: RTL and testbench

//  Emulates the SSD1306 OLED controller that sits downstream of atmega32u4_arduboy. It consumes the

---
 rtl/ssd1306_pkg.sv | 24 ++
 rtl/ssd1306_spi_capture_spi_byte_rx.sv | 75 +++++++
 rtl/ssd1306_spi_capture.sv | 207 ++++++++++++++++++++
 tb/tb_ssd1306_spi_capture.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// Shared opcodes, state enums and reset constants for the SSD1306 SPI capture block.
package ssd1306_pkg;

  localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON   = 8'hAF;
  localparam logic [7:0] CMD_INV_OFF   = 8'hA6;
  localparam logic [7:0] CMD_INV_ON    = 8'hA7;
  localparam logic [7:0] CMD_ADDR_MODE = 8'h20;
  localparam logic [7:0] CMD_CONTRAST  = 8'h81;
  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;

  localparam logic [7:0] CONTRAST_RESET = 8'h7F;

  typedef enum logic [1:0] {HORIZ = 2'd0, VERT = 2'd1, PAGE = 2'd2} addr_mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ARG1 = 2'd1, ARG2 = 2'd2} cmd_state_t;

  // Opcodes whose single argument byte is swallowed without effect.
  function automatic logic is_skip_arg_op(input logic [7:0] op);
    return (op == 8'h8D) || (op == 8'hA8) || (op == 8'hD3) || (op == 8'hD5) ||
           (op == 8'hD9) || (op == 8'hDA) || (op == 8'hDB);
  endfunction

endpackage

// File: rtl/ssd1306_spi_capture_spi_byte_rx.sv
// Pin synchroniser, SCK edge detector and MSB-first byte shifter for the OLED SPI pins.
module spi_byte_rx
  import ssd1306_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic       dc_in,
  input  logic       cs_n,
  input  logic       rst_n,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       dc,
  output logic       ctrl_rst
);

  // Bundle order {rst_n, cs_n, dc, mosi, sck}; idle values keep the controller deselected.
  localparam logic [4:0] SYNC_RESET = 5'b11000;

  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] sync_d [SYNC_STAGES];
  logic [4:0] pins_s;
  logic       sck_prev_q, sck_prev_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sck_rise;

  always_comb begin
    sync_d[0] = {rst_n, cs_n, dc_in, mosi, sck};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign pins_s   = sync_q[SYNC_STAGES-1];
  assign ctrl_rst = ~pins_s[4];
  assign dc       = pins_s[2];
  assign sck_rise = pins_s[0] & ~sck_prev_q;
  assign rx_byte  = {shift_q[6:0], pins_s[1]};

  // A deselected or held-in-reset controller drops any partial byte and ignores SCK.
  always_comb begin
    sck_prev_d = pins_s[0];
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    if (ctrl_rst || pins_s[3]) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      shift_d    = rx_byte;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      byte_valid = (bit_cnt_q == 3'd7);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= SYNC_RESET;
      end
      sck_prev_q <= 1'b0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
    end else begin
      sync_q     <= sync_d;
      sck_prev_q <= sck_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/ssd1306_spi_capture.sv
// SSD1306 emulation: decodes command/data bytes from the AVR's OLED SPI pins into framebuffer writes.
module ssd1306_spi_capture
  import ssd1306_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 8
) (
  input  logic                                     clk_avr_16,
  input  logic                                     rst,
  input  logic                                     oled_clk,
  input  logic                                     oled_data,
  input  logic                                     oled_dc,
  input  logic                                     oled_cs_n,
  input  logic                                     oled_rst_n,
  output logic                                     fb_wr_en,
  output logic [$clog2(PAGES)+$clog2(COLS)-1:0]    fb_wr_addr,
  output logic [7:0]                               fb_wr_data,
  output logic                                     display_on,
  output logic                                     invert,
  output logic [7:0]                               contrast
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  logic          byte_valid, rx_dc, ctrl_rst;
  logic [7:0]    rx_byte;

  cmd_state_t    state_q, state_d;
  addr_mode_t    mode_q, mode_d;
  logic [7:0]    op_q, op_d;
  logic [6:0]    arg1_q, arg1_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic          disp_q, disp_d, inv_q, inv_d;
  logic [7:0]    contrast_q, contrast_d;
  logic          wr_en_q, wr_en_d;
  logic [PW+CW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;

  logic          col_wrap, page_wrap;
  logic [CW-1:0] col_inc;
  logic [PW-1:0] page_inc;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk        (clk_avr_16),
    .rst        (rst),
    .sck        (oled_clk),
    .mosi       (oled_data),
    .dc_in      (oled_dc),
    .cs_n       (oled_cs_n),
    .rst_n      (oled_rst_n),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .dc         (rx_dc),
    .ctrl_rst   (ctrl_rst)
  );

  // Wrapping at the physical edge as well keeps start>end windows inside the panel.
  assign col_wrap  = (col_q == col_end_q) || (col_q == CW'(COLS - 1));
  assign page_wrap = (page_q == page_end_q) || (page_q == PW'(PAGES - 1));
  assign col_inc   = col_wrap ? col_start_q : col_q + 1'b1;
  assign page_inc  = page_wrap ? page_start_q : page_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    op_d         = op_q;
    arg1_d       = arg1_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    disp_d       = disp_q;
    inv_d        = inv_q;
    contrast_d   = contrast_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (ctrl_rst) begin
      state_d      = IDLE;
      mode_d       = PAGE;
      op_d         = 8'd0;
      arg1_d       = 7'd0;
      col_d        = '0;
      col_start_d  = '0;
      col_end_d    = CW'(COLS - 1);
      page_d       = '0;
      page_start_d = '0;
      page_end_d   = PW'(PAGES - 1);
      disp_d       = 1'b0;
      inv_d        = 1'b0;
      contrast_d   = CONTRAST_RESET;
      wr_addr_d    = '0;
      wr_data_d    = 8'd0;
    end else if (byte_valid && rx_dc) begin
      // Data always lands in GDDRAM, even if it interrupts a pending command argument.
      state_d   = IDLE;
      wr_en_d   = 1'b1;
      wr_addr_d = {page_q, col_q};
      wr_data_d = rx_byte;
      case (mode_q)
        HORIZ: begin
          col_d = col_inc;
          if (col_wrap) page_d = page_inc;
        end
        VERT: begin
          page_d = page_inc;
          if (page_wrap) col_d = col_inc;
        end
        default: col_d = col_inc;
      endcase
    end else if (byte_valid) begin
      case (state_q)
        IDLE: begin
          op_d = rx_byte;
          if (rx_byte == CMD_DISP_OFF || rx_byte == CMD_DISP_ON) begin
            disp_d = rx_byte[0];
          end else if (rx_byte == CMD_INV_OFF || rx_byte == CMD_INV_ON) begin
            inv_d = rx_byte[0];
          end else if (rx_byte == CMD_ADDR_MODE || rx_byte == CMD_CONTRAST ||
                       rx_byte == CMD_COL_ADDR || rx_byte == CMD_PAGE_ADDR ||
                       is_skip_arg_op(rx_byte)) begin
            state_d = ARG1;
          end else if (mode_q == PAGE) begin
            if (rx_byte[7:4] == 4'h0) col_d = {col_q[6:4], rx_byte[3:0]};
            else if (rx_byte[7:4] == 4'h1) col_d = {rx_byte[2:0], col_q[3:0]};
            else if (rx_byte[7:3] == 5'b10110) page_d = rx_byte[2:0];
          end
        end
        ARG1: begin
          state_d = IDLE;
          if (op_q == CMD_COL_ADDR || op_q == CMD_PAGE_ADDR) begin
            arg1_d  = rx_byte[6:0];
            state_d = ARG2;
          end else if (op_q == CMD_ADDR_MODE) begin
            mode_d = (rx_byte[1:0] == 2'd3) ? PAGE : addr_mode_t'(rx_byte[1:0]);
          end else if (op_q == CMD_CONTRAST) begin
            contrast_d = rx_byte;
          end
        end
        ARG2: begin
          state_d = IDLE;
          if (op_q == CMD_COL_ADDR) begin
            col_start_d = arg1_q[CW-1:0];
            col_end_d   = rx_byte[CW-1:0];
            col_d       = arg1_q[CW-1:0];
          end else begin
            page_start_d = arg1_q[PW-1:0];
            page_end_d   = rx_byte[PW-1:0];
            page_d       = arg1_q[PW-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_avr_16 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= PAGE;
      op_q         <= 8'd0;
      arg1_q       <= 7'd0;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLS - 1);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
      disp_q       <= 1'b0;
      inv_q        <= 1'b0;
      contrast_q   <= CONTRAST_RESET;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      op_q         <= op_d;
      arg1_q       <= arg1_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      disp_q       <= disp_d;
      inv_q        <= inv_d;
      contrast_q   <= contrast_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign fb_wr_en   = wr_en_q;
  assign fb_wr_addr = wr_addr_q;
  assign fb_wr_data = wr_data_q;
  assign display_on = disp_q;
  assign invert     = inv_q;
  assign contrast   = contrast_q;

endmodule

// File: tb/tb_ssd1306_spi_capture.sv
// Self-checking bench: SPI byte driver, queue-based controller model and write monitor.
module tb_ssd1306_spi_capture;

  logic       clk_avr_16 = 1'b0;
  logic       rst = 1'b1;
  logic       oled_clk = 1'b0;
  logic       oled_data = 1'b0;
  logic       oled_dc = 1'b0;
  logic       oled_cs_n = 1'b1;
  logic       oled_rst_n = 1'b1;
  logic       fb_wr_en;
  logic [9:0] fb_wr_addr;
  logic [7:0] fb_wr_data;
  logic       display_on;
  logic       invert;
  logic [7:0] contrast;

  int tests = 0;
  int fails = 0;

  ssd1306_spi_capture #(.SYNC_STAGES(2), .COLS(128), .PAGES(8)) dut (
    .clk_avr_16 (clk_avr_16),
    .rst        (rst),
    .oled_clk   (oled_clk),
    .oled_data  (oled_data),
    .oled_dc    (oled_dc),
    .oled_cs_n  (oled_cs_n),
    .oled_rst_n (oled_rst_n),
    .fb_wr_en   (fb_wr_en),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_data (fb_wr_data),
    .display_on (display_on),
    .invert     (invert),
    .contrast   (contrast)
  );

  always #5 clk_avr_16 = ~clk_avr_16;

  // Reference model: command bytes queue up until the opcode has all its arguments.
  int m_mode, m_cs, m_ce, m_ps, m_pe, m_col, m_page, m_disp, m_inv, m_con;
  int cmdq[$];
  int expq[$];

  function automatic int adv(input int v, input int s, input int e, input int top);
    return (v == e || v == top) ? s : v + 1;
  endfunction

  function automatic int args_needed(input int op);
    case (op)
      'h20, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB: return 1;
      'h21, 'h22: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 2; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7; m_col = 0; m_page = 0;
    m_disp = 0; m_inv = 0; m_con = 'h7F;
    cmdq.delete();
  endtask

  task automatic model_byte(input bit dc, input int b);
    int op, ncol, npage;
    bit cwrap, pwrap;
    if (dc) begin
      cmdq.delete();
      expq.push_back(((m_page * 128 + m_col) << 8) | b);
      cwrap = (m_col == m_ce || m_col == 127);
      pwrap = (m_page == m_pe || m_page == 7);
      ncol  = adv(m_col, m_cs, m_ce, 127);
      npage = adv(m_page, m_ps, m_pe, 7);
      if (m_mode == 0) begin
        m_col = ncol;
        if (cwrap) m_page = npage;
      end else if (m_mode == 1) begin
        m_page = npage;
        if (pwrap) m_col = ncol;
      end else begin
        m_col = ncol;
      end
    end else begin
      cmdq.push_back(b);
      op = cmdq[0];
      if (cmdq.size() == 1 + args_needed(op)) begin
        if (op == 'hAE || op == 'hAF) m_disp = op & 1;
        else if (op == 'hA6 || op == 'hA7) m_inv = op & 1;
        else if (op == 'h20) m_mode = ((cmdq[1] & 3) == 3) ? 2 : (cmdq[1] & 3);
        else if (op == 'h81) m_con = cmdq[1];
        else if (op == 'h21) begin
          m_cs = cmdq[1] & 127; m_ce = cmdq[2] & 127; m_col = m_cs;
        end else if (op == 'h22) begin
          m_ps = cmdq[1] & 7; m_pe = cmdq[2] & 7; m_page = m_ps;
        end else if (m_mode == 2 && op < 'h10) m_col = (m_col & 'h70) | op;
        else if (m_mode == 2 && op < 'h20) m_col = (m_col & 'h0F) | ((op & 7) << 4);
        else if (m_mode == 2 && op >= 'hB0 && op <= 'hB7) m_page = op & 7;
        cmdq.delete();
      end
    end
  endtask

  // Every observed write must match the oldest outstanding expected write.
  always @(negedge clk_avr_16) begin
    if (fb_wr_en) begin
      int exp_v;
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_write: got addr=%03h data=%02h, required no write",
                 fb_wr_addr, fb_wr_data);
      end else begin
        exp_v = expq.pop_front();
        if ({fb_wr_addr, fb_wr_data} != 18'(exp_v)) begin
          fails++;
          $display("[TB] FAIL write: got addr=%03h data=%02h, required addr=%03h data=%02h",
                   fb_wr_addr, fb_wr_data, (exp_v >> 8) & 'h3FF, exp_v & 'hFF);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic spi_bit(input logic b);
    oled_data = b;
    @(negedge clk_avr_16);
    oled_clk = 1'b1;
    repeat (2) @(negedge clk_avr_16);
    oled_clk = 1'b0;
    @(negedge clk_avr_16);
  endtask

  task automatic applyStimulus(input bit dc, input logic [7:0] b);
    model_byte(dc, int'(b));
    oled_dc   = dc;
    oled_cs_n = 1'b0;
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    repeat (3) @(negedge clk_avr_16);
  endtask

  task automatic checkOutput(input string name);
    repeat (6) @(negedge clk_avr_16);
    tests++;
    if (display_on !== 1'(m_disp) || invert !== 1'(m_inv) || contrast !== 8'(m_con)) begin
      fails++;
      $display("[TB] FAIL %s state: got on=%0b inv=%0b con=%02h, required on=%0b inv=%0b con=%02h",
               name, display_on, invert, contrast, m_disp, m_inv, m_con);
    end
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s writes: got %0d missing, required 0", name, expq.size());
      expq.delete();
    end
  endtask

  task automatic checkReset(input string name);
    tests++;
    if (fb_wr_en !== 1'b0 || fb_wr_addr !== 10'h0 || fb_wr_data !== 8'h0 ||
        display_on !== 1'b0 || invert !== 1'b0 || contrast !== 8'h7F) begin
      fails++;
      $display("[TB] FAIL %s: got en=%0b addr=%03h data=%02h on=%0b inv=%0b con=%02h, required 0 0 0 0 0 7f",
               name, fb_wr_en, fb_wr_addr, fb_wr_data, display_on, invert, contrast);
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    model_reset();
    expq.delete();
    repeat (3) @(negedge clk_avr_16);
    rst = 1'b0;
    repeat (3) @(negedge clk_avr_16);
  endtask

  typedef struct {
    bit         dc;
    logic [7:0] b;
    bit         on;
    bit         inv;
    logic [7:0] con;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] picks[13];

  initial begin
    vecs[0] = '{0, 8'hAF, 1, 0, 8'h7F};
    vecs[1] = '{0, 8'hA7, 1, 1, 8'h7F};
    vecs[2] = '{0, 8'h81, 1, 1, 8'h7F};
    vecs[3] = '{0, 8'h3C, 1, 1, 8'h3C};
    vecs[4] = '{0, 8'hD5, 1, 1, 8'h3C};
    vecs[5] = '{0, 8'h80, 1, 1, 8'h3C};
    vecs[6] = '{0, 8'hAE, 0, 1, 8'h3C};
    vecs[7] = '{0, 8'hA6, 0, 0, 8'h3C};
    picks = '{8'hAE, 8'hAF, 8'hA6, 8'hA7, 8'h20, 8'h21, 8'h22, 8'h81,
              8'hB5, 8'h03, 8'h17, 8'hD5, 8'h8D};

    model_reset();
    repeat (3) @(negedge clk_avr_16);
    rst = 1'b0;
    repeat (3) @(negedge clk_avr_16);
    checkReset("power_on");

    // Reset arriving mid-byte must discard the partial bits.
    oled_dc = 1'b1;
    oled_cs_n = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    pulseReset();
    checkReset("rst_mid_byte");
    applyStimulus(1, 8'hA5);
    checkOutput("first_data");

    // Full-screen horizontal fill, then wrap back to 000h.
    applyStimulus(0, 8'h20); applyStimulus(0, 8'h00);
    applyStimulus(0, 8'h21); applyStimulus(0, 8'h00); applyStimulus(0, 8'h7F);
    applyStimulus(0, 8'h22); applyStimulus(0, 8'h00); applyStimulus(0, 8'h07);
    for (int n = 0; n < 1025; n++) applyStimulus(1, 8'(n));
    checkOutput("horiz_fill");

    applyStimulus(0, 8'h20); applyStimulus(0, 8'h01);
    applyStimulus(0, 8'h21); applyStimulus(0, 8'h10); applyStimulus(0, 8'h11);
    applyStimulus(0, 8'h22); applyStimulus(0, 8'h02); applyStimulus(0, 8'h03);
    for (int n = 0; n < 5; n++) applyStimulus(1, 8'(8'hC0 + n));
    checkOutput("vert_window");

    applyStimulus(0, 8'h20); applyStimulus(0, 8'h02);
    applyStimulus(0, 8'h21); applyStimulus(0, 8'h00); applyStimulus(0, 8'h7F);
    applyStimulus(0, 8'h22); applyStimulus(0, 8'h00); applyStimulus(0, 8'h07);
    applyStimulus(0, 8'hB3); applyStimulus(0, 8'h05); applyStimulus(0, 8'h12);
    applyStimulus(1, 8'h11); applyStimulus(1, 8'h22);
    applyStimulus(0, 8'h21); applyStimulus(0, 8'h00); applyStimulus(0, 8'h26);
    applyStimulus(1, 8'h33); applyStimulus(1, 8'h44);
    checkOutput("page_mode");

    pulseReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].dc, vecs[i].b);
      repeat (6) @(negedge clk_avr_16);
      tests++;
      if (display_on !== vecs[i].on || invert !== vecs[i].inv || contrast !== vecs[i].con
          || fb_wr_en !== 1'b0) begin
        fails++;
        $display("[TB] FAIL vec%0d: got on=%0b inv=%0b con=%02h, required on=%0b inv=%0b con=%02h",
                 i, display_on, invert, contrast, vecs[i].on, vecs[i].inv, vecs[i].con);
      end
    end
    checkOutput("cmd_table");

    // Deselect after 5 bits; the following 81h must start a clean byte.
    pulseReset();
    oled_dc = 1'b0;
    oled_cs_n = 1'b0;
    for (int i = 0; i < 5; i++) spi_bit(1'(i & 1));
    oled_cs_n = 1'b1;
    repeat (4) @(negedge clk_avr_16);
    applyStimulus(0, 8'h81);
    applyStimulus(0, 8'h3C);
    checkOutput("cs_abort");
    applyStimulus(0, 8'h81);
    oled_rst_n = 1'b0;
    repeat (5) @(negedge clk_avr_16);
    oled_rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk_avr_16);
    checkReset("oled_rst_n");
    applyStimulus(0, 8'h3C);
    checkOutput("fsm_idle_after_pin_reset");

    pulseReset();
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(1, 8'($urandom));
      else if ($urandom_range(0, 4) == 0) applyStimulus(0, 8'($urandom));
      else applyStimulus(0, picks[$urandom_range(0, 12)]);
      if (it % 25 == 24) checkOutput("random");
    end
    checkOutput("random_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
